// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared encodings for the multicycle RISC-V control unit.
//
// Holds the sequencing state enum, the coarse ALU operation enum, the
// alu_control encodings seen by the datapath ALU, the RV32I opcode
// constants and the select values for the A, B, result and immediate muxes.
//
// Configuration macro: MC_ILLEGAL_TRAP_EN adds the TRAP state.

package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BRANCH,
        S_JAL,
        S_JALR,
`ifdef MC_ILLEGAL_TRAP_EN
        S_LUI,
        S_TRAP
`else
        S_LUI
`endif
    } state_t;

    typedef enum logic [1:0] {
        ALU_OP_ADD,
        ALU_OP_SUB,
        ALU_OP_FUNCT
    } alu_op_t;

    // The low eight codes line up with funct3, so a plain funct3 decode
    // maps directly onto {1'b0, funct3}.
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1101;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] SRC_A_PC    = 2'b00;
    localparam logic [1:0] SRC_A_OLDPC = 2'b01;
    localparam logic [1:0] SRC_A_RS1   = 2'b10;
    localparam logic [1:0] SRC_A_ZERO  = 2'b11;

    localparam logic [1:0] SRC_B_RS2  = 2'b00;
    localparam logic [1:0] SRC_B_IMM  = 2'b01;
    localparam logic [1:0] SRC_B_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    // Immediate format follows the opcode alone; formats with no immediate
    // (R-type, unknown) fall back to I, which the datapath then ignores.
    function automatic logic [2:0] imm_src_for(input logic [6:0] op);
        logic [2:0] imm;
        case (op)
            OP_STORE:         imm = IMM_S;
            OP_BRANCH:        imm = IMM_B;
            OP_JAL:           imm = IMM_J;
            OP_LUI, OP_AUIPC: imm = IMM_U;
            default:          imm = IMM_I;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/mc_control_unit_alu_decoder.sv
// mc_alu_decoder: combinational ALU operation decoder.
//
// Ports:
//   alu_op      in  2 : coarse operation from the sequencer (ADD/SUB/FUNCT)
//   funct3      in  3 : IR[14:12]
//   op5         in  1 : opcode bit 5, distinguishes R-type from I-type
//   funct7b5    in  1 : IR[30]
//   alu_control out 4 : ALU operation code

module mc_alu_decoder
    import mc_ctrl_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       op5,
    input  logic       funct7b5,
    output logic [3:0] alu_control
);

    // IR[30] only means "subtract" on R-type, because on I-type it is part
    // of the immediate; for shifts it selects arithmetic on both forms.
    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALU_OP_SUB: alu_control = ALU_SUB;
            ALU_OP_FUNCT: begin
                if (funct3 == 3'b000 && op5 && funct7b5)
                    alu_control = ALU_SUB;
                else if (funct3 == 3'b101 && funct7b5)
                    alu_control = ALU_SRA;
                else
                    alu_control = {1'b0, funct3};
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_control_unit.sv
// mc_control_unit: main control unit of the RV32I multicycle core.
//
// Sequences each instruction through the multicycle states, drives every
// datapath enable and mux select, and stretches FETCH/MEMREAD/MEMWRITE
// until the shared memory reports mem_ready.
//
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   opcode, funct3, funct7b5 : instruction register fields
//   branch_taken             : comparator result, used in BRANCH
//   mem_ready                : memory completes the access this cycle
//   pc_write, adr_src, mem_write, ir_write, reg_write : datapath enables
//   result_src, alu_src_a, alu_src_b, imm_src, alu_control : datapath selects
//   illegal_instr            : sticky illegal-opcode flag
//
// Configuration macro: MC_ILLEGAL_TRAP_EN routes unknown opcodes to a
// TRAP state that halts the core; otherwise they execute as a NOP.

module mc_control_unit
    import mc_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       branch_taken,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] imm_src,
    output logic [3:0] alu_control,
    output logic       illegal_instr
);

    state_t  state;
    state_t  next_state;
    alu_op_t alu_op;
    logic    pc_update;
    logic    branch;
    logic    mem_write_s;
    logic    ir_write_s;
    logic    reg_write_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_FETCH;
        else
            state <= next_state;
    end

    // Next state and Moore outputs; FETCH alone looks at mem_ready for its
    // enables so the IR and PC only load once the fetch really completes.
    always_comb begin
        next_state  = state;
        pc_update   = 1'b0;
        branch      = 1'b0;
        adr_src     = 1'b0;
        mem_write_s = 1'b0;
        ir_write_s  = 1'b0;
        reg_write_s = 1'b0;
        result_src  = RES_ALUOUT;
        alu_src_a   = SRC_A_PC;
        alu_src_b   = SRC_B_RS2;
        alu_op      = ALU_OP_ADD;
        case (state)
            S_FETCH: begin
                alu_src_b  = SRC_B_FOUR;
                result_src = RES_ALURESULT;
                if (mem_ready) begin
                    ir_write_s = 1'b1;
                    pc_update  = 1'b1;
                    next_state = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_a = SRC_A_OLDPC;
                alu_src_b = SRC_B_IMM;
                case (opcode)
                    OP_LOAD, OP_STORE: next_state = S_MEMADR;
                    OP_R:              next_state = S_EXECR;
                    OP_IMM:            next_state = S_EXECI;
                    OP_BRANCH:         next_state = S_BRANCH;
                    OP_JAL:            next_state = S_JAL;
                    OP_JALR:           next_state = S_JALR;
                    OP_LUI:            next_state = S_LUI;
                    OP_AUIPC:          next_state = S_ALUWB;
`ifdef MC_ILLEGAL_TRAP_EN
                    default:           next_state = S_TRAP;
`else
                    default:           next_state = S_FETCH;
`endif
                endcase
            end
            S_MEMADR: begin
                alu_src_a  = SRC_A_RS1;
                alu_src_b  = SRC_B_IMM;
                next_state = opcode[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
                if (mem_ready)
                    next_state = S_MEMWB;
            end
            S_MEMWB: begin
                result_src  = RES_DATA;
                reg_write_s = 1'b1;
                next_state  = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src     = 1'b1;
                mem_write_s = 1'b1;
                if (mem_ready)
                    next_state = S_FETCH;
            end
            S_EXECR: begin
                alu_src_a  = SRC_A_RS1;
                alu_op     = ALU_OP_FUNCT;
                next_state = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a  = SRC_A_RS1;
                alu_src_b  = SRC_B_IMM;
                alu_op     = ALU_OP_FUNCT;
                next_state = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_s = 1'b1;
                next_state  = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a  = SRC_A_RS1;
                alu_op     = ALU_OP_SUB;
                branch     = 1'b1;
                next_state = S_FETCH;
            end
            S_JAL: begin
                alu_src_a  = SRC_A_OLDPC;
                alu_src_b  = SRC_B_FOUR;
                pc_update  = 1'b1;
                next_state = S_ALUWB;
            end
            // JALR reuses JAL: ALUOut already holds the target, and JAL
            // then loads it into PC while computing OldPC+4 for rd.
            S_JALR: begin
                alu_src_a  = SRC_A_RS1;
                alu_src_b  = SRC_B_IMM;
                next_state = S_JAL;
            end
            S_LUI: begin
                alu_src_a  = SRC_A_ZERO;
                alu_src_b  = SRC_B_IMM;
                next_state = S_ALUWB;
            end
`ifdef MC_ILLEGAL_TRAP_EN
            S_TRAP: next_state = S_TRAP;
`endif
            default: next_state = S_FETCH;
        endcase
    end

    // Reset leaves the state at FETCH, which would otherwise fetch while
    // rst is still high, so every enable is masked by rst.
    assign pc_write  = ~rst & (pc_update | (branch & branch_taken));
    assign ir_write  = ~rst & ir_write_s;
    assign mem_write = ~rst & mem_write_s;
    assign reg_write = ~rst & reg_write_s;

    assign imm_src = imm_src_for(opcode);

`ifdef MC_ILLEGAL_TRAP_EN
    assign illegal_instr = (state == S_TRAP);
`else
    assign illegal_instr = 1'b0;
`endif

    mc_alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct3      (funct3),
        .op5         (opcode[5]),
        .funct7b5    (funct7b5),
        .alu_control (alu_control)
    );

endmodule

// File: doc/mc_control_unit.md
# mc_control_unit

Main control unit of the RISC-V 32I multicycle core, instantiated inside `top` next to the datapath. It runs the instruction-sequencing state machine and drives every datapath enable and mux select. It also decodes the ALU operation and stretches memory states until the shared instruction/data memory signals ready. Its inputs come from the instruction register and branch comparator; all its outputs feed the datapath.

## Interface
- No parameters; encodings come from `mc_ctrl_pkg`.
- `clk` in 1: core clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `opcode` in 7: IR[6:0].
- `funct3` in 3: IR[14:12].
- `funct7b5` in 1: IR[30].
- `branch_taken` in 1: datapath comparator result for `funct3`, valid in BRANCH.
- `mem_ready` in 1: memory completes access this cycle.
- `pc_write` out 1: PC load enable.
- `adr_src` out 1: memory address; 0 = PC, 1 = Result.
- `mem_write` out 1: memory write strobe.
- `ir_write` out 1: loads IR and OldPC.
- `reg_write` out 1: register-file write.
- `result_src` out 2: Result mux; 00 = ALUOut, 01 = Data, 10 = ALUResult.
- `alu_src_a` out 2: ALU A; 00 = PC, 01 = OldPC, 10 = rs1, 11 = zero.
- `alu_src_b` out 2: ALU B; 00 = rs2, 01 = ImmExt, 10 = 4.
- `imm_src` out 3: immediate format; 000 = I, 001 = S, 010 = B, 011 = J, 100 = U.
- `alu_control` out 4: ALU operation, encoded per package.
- `illegal_instr` out 1: sticky illegal-opcode flag.

## Operation
- State register is the only storage. Outputs are Moore from state, except:
  - `imm_src` and `alu_control` decode combinationally from the IR fields.
  - `pc_write` = `pc_update` | (`branch` & `branch_taken`).
  - `ir_write` and `pc_update` in FETCH are gated by `mem_ready`.
- Per-state behaviour (select/enable values, then next state):
  - FETCH: adr_src=0, A=00, B=10, alu_op=ADD, result_src=10. When `mem_ready`: ir_write=1, pc_update=1, go to DECODE; otherwise stay in FETCH.
  - DECODE: A=01, B=01, alu_op=ADD, so ALUOut holds OldPC+imm. Next state by opcode:
    - 0000011 or 0100011 → MEMADR.
    - 0110011 → EXECR.
    - 0010011 → EXECI.
    - 1100011 → BRANCH.
    - 1101111 → JAL.
    - 1100111 → JALR.
    - 0110111 → LUI.
    - 0010111 → ALUWB (AUIPC result is already in ALUOut).
    - Any other opcode → FETCH, or TRAP when configured.
  - MEMADR: A=10, B=01, ADD. Go to MEMREAD if opcode[5]=0, MEMWRITE if opcode[5]=1.
  - MEMREAD: adr_src=1, result_src=00. Go to MEMWB on `mem_ready`.
  - MEMWB: result_src=01, reg_write=1. Go to FETCH.
  - MEMWRITE: adr_src=1, result_src=00, mem_write=1, held while waiting. Go to FETCH on `mem_ready`.
  - EXECR: A=10, B=00, alu_op=FUNCT. Go to ALUWB.
  - EXECI: A=10, B=01, alu_op=FUNCT. Go to ALUWB.
  - ALUWB: result_src=00, reg_write=1. Go to FETCH.
  - BRANCH: A=10, B=00, alu_op=SUB, result_src=00, branch=1. Go to FETCH.
  - JAL: A=01, B=10, ADD, result_src=00, pc_update=1. Go to ALUWB, which writes OldPC+4 to rd.
  - JALR: A=10, B=01, ADD, so ALUOut = rs1+imm; the datapath clears bit 0. Go to JAL.
  - LUI: A=11, B=01, ADD. Go to ALUWB.
- ALU decode, by alu_op:
  - ADD → add.
  - SUB → sub.
  - FUNCT: sub when funct3=000 & opcode[5] & funct7b5; sra when funct3=101 & funct7b5; otherwise the op indexed by funct3.
- Outputs not listed for a state are 0 (enables) or 00 (selects).

## Timing
- Reset: state = FETCH, all enables 0, `illegal_instr` = 0, applied asynchronously.
- Enables are held at 0 while `rst`=1, even though the state is FETCH.
- Cycles per instruction with `mem_ready` held at 1:

  | Instruction | Cycles |
  |---|---|
  | lw | 5 |
  | sw | 4 |
  | R-type / I-type ALU | 4 |
  | branch | 3 |
  | jal | 4 |
  | jalr | 5 |
  | lui | 4 |
  | auipc | 3 |

- Each cycle with `mem_ready`=0 in FETCH, MEMREAD or MEMWRITE adds one cycle. While waiting, `pc_write`, `ir_write` and `reg_write` stay 0.
- `mem_write` is level-held through the whole MEMWRITE wait.
- Reset asserted mid-instruction returns to FETCH immediately, with no partial write.

## Configuration
- Macro: `MC_ILLEGAL_TRAP_EN`.
- Defined: an unknown opcode in DECODE moves to TRAP. TRAP holds every enable at 0, sets `illegal_instr`=1, and stays there until `rst`.
- Undefined: an unknown opcode returns to FETCH and executes as a 2-cycle NOP. TRAP is absent and `illegal_instr` is tied to 0.

## Structure
- `mc_ctrl_pkg` holds:
  - the state enum;
  - the alu_op enum (ADD, SUB, FUNCT);
  - the `alu_control` encodings;
  - opcode constants;
  - the select-value localparams for the A, B, result and imm muxes.
- One sub-module, `mc_alu_decoder`, maps alu_op, funct3, opcode[5] and funct7b5 to `alu_control`. It is purely combinational.

## Test plan
- add x3,x1,x2 (0x002081B3), `mem_ready`=1 → FETCH, DECODE, EXECR, ALUWB; `reg_write`=1 in cycle 4; `alu_control`=ADD.
- sub (funct7b5=1) → SUB. addi with funct7b5=1 → ADD. srai (funct3=101, funct7b5=1) → SRA.
- lw 0x0000A183 with `mem_ready`=0 for 2 MEMREAD cycles → 7 cycles total; `adr_src`=1 throughout MEMREAD; `result_src`=01 in MEMWB.
- beq with `branch_taken`=1 → `pc_write`=1 in BRANCH, 3 cycles. With `branch_taken`=0 → `pc_write` stays 0.
- jalr (0x000080E7) → FETCH, DECODE, JALR, JAL, ALUWB; `pc_write` in JAL; `reg_write` in ALUWB.
- 0xFFFFFFFF:
  - with the macro: TRAP, `illegal_instr`=1, no further fetch.
  - without the macro: back to FETCH after 2 cycles.
  - Additionally, `rst` asserted mid-MEMWRITE drops `mem_write` within the same cycle.
